// File: rtl/memory_playback_if.sv
// Playback bus: SPRAM read port toward memory_bank plus the sample
// valid/ready stream toward the DAC/SPI consumer.
interface memory_playback_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_dataout;
   logic [DATA_W-1:0] sample;
   logic              sample_valid;
   logic              sample_ready;

   modport master (
      output mem_address, mem_rd_en, sample, sample_valid,
      input  mem_dataout, sample_ready
   );

   modport slave (
      input  mem_address, mem_rd_en, sample, sample_valid,
      output mem_dataout, sample_ready
   );
endinterface

// File: rtl/memory_playback.sv
// Streams captured samples out of the SPRAM at a fixed rate, one
// address per sample tick, onto a valid/ready sample port.
module memory_playback #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int SAMPLE_DIV = 480
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W:0]   length,
   memory_playback_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              late
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      READ,
      LATCH
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] sample_q;
   logic              valid_q;
   logic              tick;
   logic              accept;

   assign tick   = (div == DIV_W'(SAMPLE_DIV - 1));
   assign accept = valid_q & bus.sample_ready;

   assign bus.mem_address  = addr;
   assign bus.mem_rd_en    = busy;
   assign bus.sample       = sample_q;
   assign bus.sample_valid = valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div       <= '0;
         addr      <= '0;
         last_addr <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         late      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept)
            valid_q <= 1'b0;
         if (state != IDLE)
            div <= tick ? '0 : div + DIV_W'(1);

         if (stop && state != IDLE) begin
            state   <= IDLE;
            busy    <= 1'b0;
            valid_q <= 1'b0;
            div     <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && length != '0) begin
                     // Lengths beyond the address space clamp to a full sweep
                     last_addr <= length[ADDR_W] ? '1
                                : length[ADDR_W-1:0] - ADDR_W'(1);
                     addr  <= '0;
                     div   <= '0;
                     late  <= 1'b0;
                     busy  <= 1'b1;
                     state <= WAIT_TICK;
                  end
               end
               WAIT_TICK: begin
                  if (tick) begin
                     if (!valid_q || bus.sample_ready)
                        state <= READ;
                     else
                        late <= 1'b1;
                  end
               end
               READ: state <= LATCH;
               LATCH: begin
                  sample_q <= bus.mem_dataout;
                  valid_q  <= 1'b1;
                  if (addr != last_addr) begin
                     addr  <= addr + ADDR_W'(1);
                     state <= WAIT_TICK;
                  end else if (loop_en) begin
                     addr  <= '0;
                     state <= WAIT_TICK;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     div   <= '0;
                     state <= IDLE;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_memory_playback.sv
// Directed plus randomized bench for memory_playback with a small
// address space so full-length wrap is reachable.
module tb_memory_playback;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int DIV    = 8;
   localparam int FULL   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stop;
   logic              loop_en;
   logic [ADDR_W:0]   length;
   logic              busy;
   logic              done;
   logic              late;
   int                ready_mode;

   int                vectors;
   int                miscompares;
   int                cyc;
   int                done_cnt;
   logic [DATA_W-1:0] got_q[$];
   int                got_t[$];

   memory_playback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   memory_playback #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .SAMPLE_DIV(DIV)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .stop   (stop),
      .loop_en(loop_en),
      .length (length),
      .bus    (bus.master),
      .busy   (busy),
      .done   (done),
      .late   (late)
   );

   always #5 clk = ~clk;

   // SPRAM model: one-cycle read latency, data = addr ^ A5A5
   always @(posedge clk)
      bus.mem_dataout <= DATA_W'(bus.mem_address) ^ 16'hA5A5;

   always @(negedge clk) begin
      case (ready_mode)
         0:       bus.sample_ready = 1'b0;
         1:       bus.sample_ready = 1'b1;
         default: bus.sample_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(posedge clk) begin
      cyc++;
      if (bus.sample_valid && bus.sample_ready) begin
         got_q.push_back(bus.sample);
         got_t.push_back(cyc);
      end
      if (done)
         done_cnt++;
   end

   function automatic logic [DATA_W-1:0] ref_sample(input int len, input int i);
      int n;
      n = (len > FULL) ? FULL : len;
      return DATA_W'(i % n) ^ 16'hA5A5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W:0] l);
      @(negedge clk);
      length = l;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic wait_got(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (got_q.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_count"}, got_q.size() >= target, 1);
   endtask

   task automatic check_seq(input string tag, input int base, input int len,
                            input int cnt);
      for (int i = 0; i < cnt; i++)
         check($sformatf("%s_s%0d", tag, i), got_q[base+i], ref_sample(len, i));
   endtask

   initial begin
      int base;
      int dbase;
      int n;
      int len;
      logic hold_ok;

      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      done_cnt    = 0;
      reset       = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      loop_en     = 1'b0;
      length      = '0;
      ready_mode  = 1;
      repeat (3) @(negedge clk);

      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_late", late, 0);
      check("rst_valid", bus.sample_valid, 0);
      check("rst_sample", bus.sample, 0);
      check("rst_addr", bus.mem_address, 0);
      check("rst_rden", bus.mem_rd_en, 0);
      reset = 1'b0;

      // 1: plain 4-sample playback
      base  = got_q.size();
      dbase = done_cnt;
      pulse_start(5'd4);
      check("t1_rden", bus.mem_rd_en, 1);
      wait_idle(200, "t1");
      repeat (3) @(negedge clk);
      check("t1_n", got_q.size() - base, 4);
      check_seq("t1", base, 4, 4);
      for (int i = 1; i < 4; i++)
         check($sformatf("t1_gap%0d", i), got_t[base+i] - got_t[base+i-1], DIV);
      check("t1_done", done_cnt - dbase, 1);
      check("t1_late", late, 0);

      // 2: looped length 3, then stop
      base    = got_q.size();
      dbase   = done_cnt;
      loop_en = 1'b1;
      pulse_start(5'd3);
      wait_got(base + 9, 300, "t2");
      check_seq("t2", base, 3, 9);
      check("t2_busy", busy, 1);
      check("t2_done", done_cnt - dbase, 0);
      stop = 1'b1;
      @(negedge clk);
      stop    = 1'b0;
      loop_en = 1'b0;
      check("t2_stop_busy", busy, 0);
      check("t2_stop_valid", bus.sample_valid, 0);
      check("t2_stop_rden", bus.mem_rd_en, 0);

      // 3: consumer stalls, first sample held, late set
      ready_mode = 0;
      @(negedge clk);
      base = got_q.size();
      pulse_start(5'd4);
      n = 0;
      while (!bus.sample_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t3_valid", bus.sample_valid, 1);
      hold_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.sample !== 16'hA5A5 || !bus.sample_valid || bus.mem_address !== 4'd1)
            hold_ok = 1'b0;
      end
      check("t3_hold", hold_ok, 1);
      check("t3_late", late, 1);
      ready_mode = 1;
      wait_idle(300, "t3");
      repeat (3) @(negedge clk);
      check("t3_n", got_q.size() - base, 4);
      check_seq("t3", base, 4, 4);
      check("t3_late_sticky", late, 1);

      // 4: zero length ignored; start while busy ignored
      dbase = done_cnt;
      pulse_start(5'd0);
      repeat (4) @(negedge clk);
      check("t4_zero_busy", busy, 0);
      check("t4_zero_done", done_cnt - dbase, 0);
      base = got_q.size();
      pulse_start(5'd2);
      repeat (3) @(negedge clk);
      pulse_start(5'd6);
      wait_idle(200, "t4");
      repeat (3) @(negedge clk);
      check("t4_n", got_q.size() - base, 2);
      check("t4_done", done_cnt - dbase, 1);

      // 5: stop right after sample 2 is latched
      dbase = done_cnt;
      pulse_start(5'd4);
      n = 0;
      while (!(bus.sample_valid && bus.sample == 16'hA5A4) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t5_seen2", bus.sample, 16'hA5A4);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_valid", bus.sample_valid, 0);
      repeat (DIV * 2) @(negedge clk);
      check("t5_done", done_cnt - dbase, 0);
      base = got_q.size();
      pulse_start(5'd2);
      wait_idle(200, "t5r");
      repeat (3) @(negedge clk);
      check("t5_replay_n", got_q.size() - base, 2);
      check_seq("t5r", base, 2, 2);

      // randomized lengths and consumer back-pressure
      for (int k = 0; k < 6; k++) begin
         len        = $urandom_range(1, FULL + 4);
         ready_mode = 2;
         base       = got_q.size();
         dbase      = done_cnt;
         pulse_start(5'(len));
         wait_idle(400 + len * 40, $sformatf("r%0d", k));
         ready_mode = 1;
         repeat (3) @(negedge clk);
         n = (len > FULL) ? FULL : len;
         check($sformatf("r%0d_n", k), got_q.size() - base, n);
         if (got_q.size() - base >= n)
            check_seq($sformatf("r%0d", k), base, len, n);
         check($sformatf("r%0d_done", k), done_cnt - dbase, 1);
      end

      // 6: over-length clamps to full sweep, wrap last address to 0
      base    = got_q.size();
      loop_en = 1'b1;
      pulse_start(5'(FULL + 4));
      wait_got(base + FULL + 2, 600, "t6");
      check("t6_last", got_q[base+FULL-1], 16'hA5AA);
      check("t6_wrap", got_q[base+FULL], 16'hA5A5);
      check("t6_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", bus.sample_valid, 0);
      check("t6_rst_sample", bus.sample, 0);
      check("t6_rst_addr", bus.mem_address, 0);
      check("t6_rst_rden", bus.mem_rd_en, 0);
      check("t6_rst_late", late, 0);
      reset   = 1'b0;
      loop_en = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
